pending_encoder_32x5: RTL and testbench
=======================================

// Module: pending_encoder_32x5
// PURPOSE
//  Sequential 32-to-5 priority encoder with handshake; the encode-side counterpart of the 5x32 line decoder.
//  Collects sticky request bits (interrupt/event sources) and presents the index of the lowest masked pending bit.
//  Holds that index with VALID until the consumer ACKs, then clears the serviced bit.
//  Sits between event sources and the control unit; its IDX drives the 5x32 decoder select path.
// PARAMETERS
//  WIDTH  32  number of request lines
//  IDX_W  5   index width; must equal log2(WIDTH)
// PORTS
//  CLK      in   1      clock; all state updates on posedge
//  RESET    in   1      asynchronous, active-high reset
//  REQ      in   WIDTH  request pulses; bit i high at an edge sets PENDING[i]
//  MASK     in   WIDTH  1 = line eligible for selection; masked lines still accumulate
//  ACK      in   1      consumer accepts the presented IDX; honoured only while VALID=1
//  IDX      out  IDX_W  index of the selected pending line
//  VALID    out  1      IDX is valid and stable
//  PENDING  out  WIDTH  current sticky pending vector
// BEHAVIOUR
//  Interface: one clock (CLK); RESET is asynchronous and active-high.
//  Reset (async, immediate): PENDING=0, VALID=0, IDX=0, state=IDLE. On deassertion, resume at the next posedge.
//  Pending update per edge: PENDING <= (PENDING & ~clr) | REQ.
//    clr is one-hot at IDX when VALID&ACK, else 0.
//    Set wins over clear: REQ[i] and an ACK clearing i in the same cycle leaves PENDING[i]=1.
//  Selection: sel = lowest i with (PENDING[i] & MASK[i]) = 1.
//    Uses the registered PENDING, not the same-cycle REQ.
//  FSM, 2 states:
//    IDLE: if (PENDING & MASK) != 0 -> IDX<=sel, VALID<=1, go PRESENT; else stay, VALID=0, IDX holds.
//    PRESENT: IDX and VALID held constant.
//      MASK and REQ changes do not alter IDX; masking the presented line does not withdraw it.
//      ACK=1 -> clear PENDING[IDX], VALID<=0, go IDLE.
//      ACK=0 -> stay.
//  ACK while VALID=0: ignored; no state change, no clear.
//  Latency:
//    REQ sampled at edge k -> PENDING after k -> VALID after edge k+1, i.e. 2 cycles.
//    ACK at edge j -> VALID=0 after j -> earliest next VALID after j+1.
//    Minimum 1-cycle VALID-low bubble between grants.
//  Repeated REQ on an already-pending line: no effect; there is no counting. Lost multiplicity is acceptable.
//  All-zero masked vector: VALID stays 0 and IDX retains its last value.
//  IDX is driven from a register, not combinationally from PENDING, so it is glitch-free while VALID=1.
//  Widths: IDX zero-extends nothing. WIDTH=2^IDX_W is mandatory; any other value is a compile-time error.
// TESTING
//  1. Reset: RESET=1 mid-PRESENT with IDX=7 -> PENDING=0, VALID=0, IDX=0 immediately, before the next edge.
//  2. Single: MASK=all-ones, REQ=0x0000_0020 for 1 cycle -> VALID=1 two edges later, IDX=5.
//     ACK 1 cycle -> PENDING=0, VALID=0.
//  3. Priority: PENDING=0x8000_0011, all enabled -> grants IDX=0, then 4, then 31 on successive ACKs.
//     Each grant is preceded by a 1-cycle VALID-low gap.
//  4. Mask: PENDING=0x0000_0003, MASK=0xFFFF_FFFE -> IDX=1 granted; bit0 stays pending, VALID=0 after ACK.
//     Set MASK=all-ones -> IDX=0 granted.
//  5. Set-vs-clear: VALID=1, IDX=3, ACK=1 with REQ=0x8 same edge -> PENDING[3]=1.
//     IDX=3 is re-granted after the bubble.
//  6. Hold: VALID=1, IDX=9, then MASK=0 and REQ=0x1 with ACK=0 for 5 cycles -> IDX=9 and VALID=1 throughout.
//     Stray ACK while VALID=0 -> no PENDING change.

Source files
------------

// File: rtl/pending_encoder_32x5.sv
// Sticky 32-line request collector with registered lowest-index priority grant and ACK handshake.
// A grant is held until ACK; only then is the serviced pending bit cleared.
module pending_encoder_32x5 #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic             ack_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] pending_o
);

    generate
        if (WIDTH != (32'd1 << IDX_W)) begin : g_width_check
            $error("pending_encoder_32x5: WIDTH must equal 2**IDX_W");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] pending_d;
    logic [WIDTH-1:0] eligible_c;
    logic [WIDTH-1:0] clr_c;
    logic [IDX_W-1:0] sel_c;
    logic             any_c;

    // Lowest-index eligible line; scanning downward lets the lowest match win.
    always_comb begin
        eligible_c = pending_q & mask_i;
        any_c      = |eligible_c;
        sel_c      = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (eligible_c[i]) begin
                sel_c = IDX_W'(i);
            end
        end
    end

    // A new request on the line being acknowledged survives the clear.
    always_comb begin
        clr_c     = (valid_q && ack_i) ? (WIDTH'(1) << idx_q) : '0;
        pending_d = (pending_q & ~clr_c) | req_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        idx_q   <= sel_c;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign idx_o     = idx_q;
    assign valid_o   = valid_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_pending_encoder_32x5.sv
// Directed bench for pending_encoder_32x5: reset, single grant, priority, mask, set-vs-clear, hold.
module tb_pending_encoder_32x5;

    logic        clk;
    logic        rst;
    logic [31:0] req;
    logic [31:0] mask;
    logic        ack;
    logic [4:0]  idx;
    logic        valid;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    pending_encoder_32x5 dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .mask_i    (mask),
        .ack_i     (ack),
        .idx_o     (idx),
        .valid_o   (valid),
        .pending_o (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] i, input logic [31:0] p);
        chk({tag, "_valid"}, 32'(valid), 32'(v));
        if (v) chk({tag, "_idx"}, 32'(idx), 32'(i));
        chk({tag, "_pending"}, pending, p);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        mask = '1;
        ack  = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("reset_pending", pending, 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_idx", 32'(idx), 32'h0);

        // Single request on line 5
        req = 32'h0000_0020;
        step();
        req = '0;
        chk_out("single_k", 1'b0, 5'd0, 32'h0000_0020);
        step();
        chk_out("single_k1", 1'b1, 5'd5, 32'h0000_0020);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("single_ack", 1'b0, 5'd0, 32'h0);
        step();
        chk_out("single_idle", 1'b0, 5'd0, 32'h0);

        // Priority 0, 4, 31 with bubbles
        req = 32'h8000_0011;
        step();
        req = '0;
        step();
        chk_out("prio_g0", 1'b1, 5'd0, 32'h8000_0011);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("prio_gap0", 1'b0, 5'd0, 32'h8000_0010);
        step();
        chk_out("prio_g4", 1'b1, 5'd4, 32'h8000_0010);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("prio_gap4", 1'b0, 5'd0, 32'h8000_0000);
        step();
        chk_out("prio_g31", 1'b1, 5'd31, 32'h8000_0000);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("prio_done", 1'b0, 5'd0, 32'h0);

        // Masked line 0 keeps accumulating but is not granted
        mask = 32'hFFFF_FFFE;
        req  = 32'h0000_0003;
        step();
        req = '0;
        step();
        chk_out("mask_g1", 1'b1, 5'd1, 32'h0000_0003);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("mask_ack1", 1'b0, 5'd0, 32'h0000_0001);
        step();
        chk_out("mask_blocked", 1'b0, 5'd0, 32'h0000_0001);
        chk("mask_idx_hold", 32'(idx), 32'd1);
        mask = '1;
        step();
        chk_out("mask_g0", 1'b1, 5'd0, 32'h0000_0001);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("mask_done", 1'b0, 5'd0, 32'h0);

        // Set wins over clear on line 3
        req = 32'h0000_0008;
        step();
        req = '0;
        step();
        chk_out("setclr_g3", 1'b1, 5'd3, 32'h0000_0008);
        ack = 1'b1;
        req = 32'h0000_0008;
        step();
        ack = 1'b0;
        req = '0;
        chk_out("setclr_keep", 1'b0, 5'd0, 32'h0000_0008);
        step();
        chk_out("setclr_regrant", 1'b1, 5'd3, 32'h0000_0008);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk_out("setclr_done", 1'b0, 5'd0, 32'h0);

        // Presented index held against mask and request changes
        req = 32'h0000_0200;
        step();
        req = '0;
        step();
        chk_out("hold_g9", 1'b1, 5'd9, 32'h0000_0200);
        mask = '0;
        req  = 32'h0000_0001;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("hold_valid", 32'(valid), 32'h1);
            chk("hold_idx", 32'(idx), 32'd9);
        end
        chk("hold_pending", pending, 32'h0000_0201);
        req = '0;
        ack = 1'b1;
        step();
        chk_out("hold_ack", 1'b0, 5'd0, 32'h0000_0001);
        // Stray ACK while not valid
        step();
        ack = 1'b0;
        chk_out("stray_ack", 1'b0, 5'd0, 32'h0000_0001);
        chk("stray_idx_hold", 32'(idx), 32'd9);

        // Async reset mid-PRESENT with IDX=7
        mask = '1;
        step();
        chk_out("pre_g0", 1'b1, 5'd0, 32'h0000_0001);
        ack = 1'b1;
        step();
        ack = 1'b0;
        req = 32'h0000_0080;
        step();
        req = '0;
        step();
        chk_out("pre_g7", 1'b1, 5'd7, 32'h0000_0080);
        #2;
        rst = 1'b1;
        #1;
        chk("async_pending", pending, 32'h0);
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_idx", 32'(idx), 32'h0);
        #1;
        rst = 1'b0;
        step();
        chk_out("post_reset", 1'b0, 5'd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
